node_stream_reader: RTL and testbench
=====================================

# node_stream_reader

Consumer of the packed node-position buses driven by a simulation core. On request it snapshots every node's (x, y) in one cycle, then streams the positions out one node per valid/ready handshake, in index order, with a last-node marker. It sits between the cores and the display/host link, so the link can read a coherent frame while the cores keep relaxing positions every cycle.

## Interface
- NODE_COUNT, 5, nodes per snapshot; must be ≥ 2.
- X_MAX, 32'd639, upper clip bound for x; used only with NODE_STREAM_CLIP_EN.
- Y_MAX, 32'd479, upper clip bound for y; used only with NODE_STREAM_CLIP_EN.
- IDX_W, $clog2(NODE_COUNT), width of out_index (local).
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- nodes_x  in  NODE_COUNT*32  packed x; node i at [(i+1)*32-1 : i*32].
- nodes_y  in  NODE_COUNT*32  packed y; same packing as nodes_x.
- frame_req  in  1  level request to snapshot and stream one frame.
- out_ready  in  1  downstream can accept this cycle.
- out_valid  out  1  out_x/out_y/out_index/out_last hold a valid node.
- out_x  out  32  x of the current node.
- out_y  out  32  y of the current node.
- out_index  out  IDX_W  node index, 0..NODE_COUNT-1.
- out_last  out  1  high with out_valid when out_index == NODE_COUNT-1.
- busy  out  1  high in STREAM.
- frame_done  out  1  one-cycle pulse after the last node's handshake.
- frame_count  out  16  count of completed frames; wraps at 65535 to 0.
- out_clipped  out  1  present only with NODE_STREAM_CLIP_EN; high while the current coordinate was clamped.

## Operation
- States: IDLE, STREAM.
- IDLE, frame_req=1 at a clock edge:
  - Copy all nodes_x/nodes_y into the shadow registers.
  - Set index to 0 and move to STREAM.
- IDLE, frame_req=0: stay in IDLE.
- STREAM:
  - out_valid=1.
  - Outputs come from shadow[index].
  - A transfer happens on a cycle with out_valid & out_ready.
- On a transfer with index < NODE_COUNT-1: index increments by 1.
- On a transfer with index == NODE_COUNT-1: go to IDLE and raise frame_done on the next cycle.
- frame_count increments in the same cycle as frame_done.
- Changes on nodes_x/nodes_y during STREAM do not affect the output. Only the snapshot is streamed.
- frame_req in STREAM is ignored and not queued. If frame_req is still high in IDLE, the next snapshot is taken.
- Outputs stay stable while out_valid=1 and out_ready=0.
- Reset values (all registers and outputs): state IDLE, out_valid 0, out_x 0, out_y 0, out_index 0, out_last 0, busy 0, frame_done 0, frame_count 0, shadow registers 0, out_clipped 0.
- Reset during STREAM aborts the frame. The following cycle shows the reset values, and frame_done does not pulse.

## Timing
- Snapshot edge T with frame_req=1 in IDLE: out_valid=1 with index 0 from cycle T+1.
- With out_ready held high, node i is presented in cycle T+1+i.
- Last transfer in cycle L:
  - out_valid=0, busy=0 and frame_done=1 in cycle L+1.
  - frame_req sampled high at the end of L+1 gives out_valid=1 at L+2.
  - Minimum gap between frames: one cycle with out_valid=0.
- Fixed latency from request to first data: 1 cycle. No combinational path from out_ready to out_valid or to the data outputs.

## Configuration
- NODE_STREAM_CLIP_EN defined:
  - Inputs are treated as signed 32-bit.
  - Negative values are clamped to 0; x > X_MAX becomes X_MAX and y > Y_MAX becomes Y_MAX.
  - Clamping is applied at the snapshot edge.
  - A per-node clip flag is stored with the snapshot and drives out_clipped.
- NODE_STREAM_CLIP_EN undefined: raw values pass through and the out_clipped port does not exist.

## Test plan
- Single frame, out_ready=1, NODE_COUNT=5, node i at x=10*(i+1), y=100+i:
  - Pulse frame_req for 1 cycle → five beats (10,100)…(50,104), indices 0–4.
  - out_last only on beat 4; frame_done one cycle later; frame_count=1.
- Backpressure: out_ready low for 3 cycles at index 2 → out_x=30, out_y=102 and index 2 held stable, with no skipped or duplicated beats.
- Coherence: change every nodes_x to 32'hFFFF_FFFF during STREAM → all five beats still carry the snapshot values.
- Back-to-back: frame_req held high for 20 cycles with out_ready=1 → frames of 5 beats, each separated by exactly one cycle with out_valid=0, and frame_count increments per frame.
- Reset mid-stream at index 3 → next cycle out_valid=0, frame_count=0, no frame_done pulse; a new frame_req streams from index 0.
- Clip (macro defined): x=-5, y=500 → out_x=0, out_y=479, out_clipped=1. x=100, y=100 → out_clipped=0.

Source files
------------

// File: rtl/node_stream_reader.sv
// rtl/node_stream_reader.sv - snapshot packed node positions and stream them one node per handshake
// Optional clamping of coordinates at snapshot time is enabled by defining NODE_STREAM_CLIP_EN.
module node_stream_reader #(
    parameter int          NODE_COUNT = 5,
    parameter logic [31:0] X_MAX      = 32'd639,
    parameter logic [31:0] Y_MAX      = 32'd479,
    localparam int         IDX_W      = $clog2(NODE_COUNT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NODE_COUNT*32-1:0] nodes_x,
    input  logic [NODE_COUNT*32-1:0] nodes_y,
    input  logic                    frame_req,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [31:0]             out_x,
    output logic [31:0]             out_y,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_last,
    output logic                    busy,
    output logic                    frame_done,
`ifdef NODE_STREAM_CLIP_EN
    output logic                    out_clipped,
`endif
    output logic [15:0]             frame_count
);

    localparam logic [0:0] STATE_IDLE   = 1'b0;
    localparam logic [0:0] STATE_STREAM = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODE_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
`ifdef NODE_STREAM_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [31:0]      shadow_x_q [NODE_COUNT];
    logic [31:0]      shadow_x_d [NODE_COUNT];
    logic [31:0]      shadow_y_q [NODE_COUNT];
    logic [31:0]      shadow_y_d [NODE_COUNT];
    logic             frame_done_q, frame_done_d;
    logic [15:0]      frame_count_q, frame_count_d;

    // Coordinates are signed: negatives clamp to 0, values above the bound clamp to it.
    function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] maxv);
        if ($signed(v) < 0)                 return 32'd0;
        else if ($signed(v) > $signed(maxv)) return maxv;
        else                                 return v;
    endfunction

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        shadow_x_d    = shadow_x_q;
        shadow_y_d    = shadow_y_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        case (state_q)
            STATE_IDLE: begin
                if (frame_req) begin
                    for (int i = 0; i < NODE_COUNT; i++) begin
                        shadow_x_d[i] = CLIP_EN ? clamp(nodes_x[i*32 +: 32], X_MAX) : nodes_x[i*32 +: 32];
                        shadow_y_d[i] = CLIP_EN ? clamp(nodes_y[i*32 +: 32], Y_MAX) : nodes_y[i*32 +: 32];
                    end
                    index_d = '0;
                    state_d = STATE_STREAM;
                end
            end
            default: begin
                if (out_ready) begin
                    if (index_q == LAST_IDX) begin
                        state_d       = STATE_IDLE;
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 16'd1;
                    end else begin
                        index_d = index_q + IDX_ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= STATE_IDLE;
            index_q       <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= 16'd0;
            for (int i = 0; i < NODE_COUNT; i++) begin
                shadow_x_q[i] <= 32'd0;
                shadow_y_q[i] <= 32'd0;
            end
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            shadow_x_q    <= shadow_x_d;
            shadow_y_q    <= shadow_y_d;
        end
    end

`ifdef NODE_STREAM_CLIP_EN
    logic [NODE_COUNT-1:0] clip_q, clip_d;

    always_comb begin
        clip_d = clip_q;
        if (state_q == STATE_IDLE && frame_req) begin
            for (int i = 0; i < NODE_COUNT; i++) begin
                clip_d[i] = (clamp(nodes_x[i*32 +: 32], X_MAX) != nodes_x[i*32 +: 32]) ||
                            (clamp(nodes_y[i*32 +: 32], Y_MAX) != nodes_y[i*32 +: 32]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) clip_q <= '0;
        else       clip_q <= clip_d;
    end

    assign out_clipped = out_valid & clip_q[index_q];
`endif

    // Data outputs read the registered snapshot only; out_ready never reaches them combinationally.
    assign out_valid   = (state_q == STATE_STREAM);
    assign busy        = out_valid;
    assign out_x       = out_valid ? shadow_x_q[index_q] : 32'd0;
    assign out_y       = out_valid ? shadow_y_q[index_q] : 32'd0;
    assign out_index   = out_valid ? index_q : '0;
    assign out_last    = out_valid && (index_q == LAST_IDX);
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_node_stream_reader.sv
// tb/tb_node_stream_reader.sv - randomized and directed bench for node_stream_reader against a beat-queue model
module tb_node_stream_reader;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*32-1:0] nodes_x, nodes_y;
    logic           frame_req, out_ready;
    logic           out_valid, out_last, busy, frame_done;
    logic [31:0]    out_x, out_y;
    logic [2:0]     out_index;
    logic [15:0]    frame_count;
`ifdef NODE_STREAM_CLIP_EN
    logic           out_clipped;
`endif

    node_stream_reader #(.NODE_COUNT(N)) dut (
        .clk(clk), .reset(reset), .nodes_x(nodes_x), .nodes_y(nodes_y),
        .frame_req(frame_req), .out_ready(out_ready), .out_valid(out_valid),
        .out_x(out_x), .out_y(out_y), .out_index(out_index), .out_last(out_last),
        .busy(busy), .frame_done(frame_done),
`ifdef NODE_STREAM_CLIP_EN
        .out_clipped(out_clipped),
`endif
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        int          idx;
        logic        clip;
    } beat_t;

    beat_t       q[$];
    logic        exp_done = 1'b0;
    logic [15:0] exp_count = 16'd0;
    int          compared = 0;
    int          mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_clamp(input logic [31:0] v, input int maxv);
        int sv = int'(v);
        if (sv < 0)    return 32'd0;
        if (sv > maxv) return 32'(maxv);
        return v;
    endfunction

    // A frame request while nothing is pending queues one whole frame of beats.
    task automatic snapshot();
        for (int i = 0; i < N; i++) begin
            beat_t b;
            b.idx = i;
`ifdef NODE_STREAM_CLIP_EN
            b.x    = ref_clamp(nodes_x[i*32 +: 32], 639);
            b.y    = ref_clamp(nodes_y[i*32 +: 32], 479);
            b.clip = (b.x != nodes_x[i*32 +: 32]) || (b.y != nodes_y[i*32 +: 32]);
`else
            b.x    = nodes_x[i*32 +: 32];
            b.y    = nodes_y[i*32 +: 32];
            b.clip = 1'b0;
`endif
            q.push_back(b);
        end
    endtask

    task automatic check_outputs();
        logic v;
        v = (q.size() != 0);
        chk("out_valid", out_valid, v);
        chk("busy", busy, v);
        chk("frame_done", frame_done, exp_done);
        chk("frame_count", frame_count, exp_count);
        if (v) begin
            chk("out_x", out_x, q[0].x);
            chk("out_y", out_y, q[0].y);
            chk("out_index", out_index, q[0].idx);
            chk("out_last", out_last, q[0].idx == N - 1);
`ifdef NODE_STREAM_CLIP_EN
            chk("out_clipped", out_clipped, q[0].clip);
`endif
        end else begin
            chk("out_last_idle", out_last, 1'b0);
        end
    endtask

    task automatic cycle(input logic req, input logic rdy);
        frame_req = req;
        out_ready = rdy;
        exp_done  = 1'b0;
        if (q.size() != 0) begin
            if (rdy) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    exp_done  = 1'b1;
                    exp_count = exp_count + 16'd1;
                end
            end
        end else if (req) begin
            snapshot();
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic reset_cycle();
        reset     = 1'b1;
        frame_req = 1'b0;
        q.delete();
        exp_done  = 1'b0;
        exp_count = 16'd0;
        @(negedge clk);
        check_outputs();
        chk("reset_out_x", out_x, 32'd0);
        chk("reset_out_y", out_y, 32'd0);
        chk("reset_out_index", out_index, 32'd0);
        reset = 1'b0;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < N; i++) begin
            nodes_x[i*32 +: 32] = 32'(10 * (i + 1));
            nodes_y[i*32 +: 32] = 32'(100 + i);
        end
    endtask

    task automatic random_nodes();
        for (int i = 0; i < N; i++) begin
            nodes_x[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 700);
            nodes_y[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 700);
        end
    endtask

    initial begin
        logic [15:0] cnt0;
        reset = 1'b1; frame_req = 1'b0; out_ready = 1'b0;
        nodes_x = '0; nodes_y = '0;
        @(negedge clk);
        reset_cycle();

        // Single frame with out_ready high.
        set_ramp();
        cycle(1'b1, 1'b1);
        chk("first_x", out_x, 32'd10);
        chk("first_y", out_y, 32'd100);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
        chk("single_count", frame_count, 16'd1);

        // Backpressure at index 2.
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0);
            chk("bp_x", out_x, 32'd30);
            chk("bp_y", out_y, 32'd102);
            chk("bp_index", out_index, 32'd2);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);

        // Coherence: inputs change after the snapshot.
        cycle(1'b1, 1'b1);
        for (int i = 0; i < N; i++) nodes_x[i*32 +: 32] = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        set_ramp();

        // Back-to-back frames with frame_req held high.
        cnt0 = exp_count;
        for (int i = 0; i < 20; i++) begin
            random_nodes();
            cycle(1'b1, 1'b1);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
        chk("b2b_frames", frame_count, cnt0 + 16'd4);

        // Reset mid-stream at index 3.
        set_ramp();
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        chk("pre_reset_index", out_index, 32'd3);
        reset_cycle();
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        chk("after_reset_index", out_index, 32'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);

`ifdef NODE_STREAM_CLIP_EN
        nodes_x[31:0]  = 32'hFFFF_FFFB;
        nodes_y[31:0]  = 32'd500;
        nodes_x[63:32] = 32'd100;
        nodes_y[63:32] = 32'd100;
        cycle(1'b1, 1'b1);
        chk("clip_x", out_x, 32'd0);
        chk("clip_y", out_y, 32'd479);
        chk("clip_flag", out_clipped, 1'b1);
        cycle(1'b0, 1'b1);
        chk("noclip_flag", out_clipped, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            random_nodes();
            cycle(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
